// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory,
// and drives the IF/ID register with a one-entry skid buffer for decode stalls.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump,
   input  logic [25:0] jump_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] command,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        valid
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_DROP  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [1:0]  state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] tgt_r, tgt_s;
   logic [31:0] skid_cmd_r, skid_cmd_s;
   logic [31:0] skid_pc_r, skid_pc_s;
   logic        req_r;
   logic [31:0] cmd_r, cmd_s;
   logic [31:0] pco_r, pco_s;
   logic        valid_r, valid_s;
   logic        ack_s;
   logic        redirect_s;
   logic [31:0] redir_tgt_s;

   // An ack only counts when a request is actually outstanding
   assign ack_s       = imem_ack & req_r;
   assign redirect_s  = br_taken | (jump & valid_r & ~stall);
   assign redir_tgt_s = br_taken ? br_target : {pc_plus4[31:28], jump_addr, 2'b00};

   assign imem_req  = req_r;
   assign imem_addr = pc_r;
   assign command   = cmd_r;
   assign pc_out    = pco_r;
   assign valid     = valid_r;
   assign pc_plus4  = pco_r + 32'd4;

   // Next-state, PC, skid and IF/ID selection
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      tgt_s      = tgt_r;
      skid_cmd_s = skid_cmd_r;
      skid_pc_s  = skid_pc_r;
      pco_s      = pco_r;
      // IF/ID holds only under a stall that is not being flushed
      if (redirect_s || !stall) begin
         cmd_s   = NOP_WORD;
         valid_s = 1'b0;
      end else begin
         cmd_s   = cmd_r;
         valid_s = valid_r;
      end
      case (state_r)
         ST_FETCH: begin
            if (redirect_s) begin
               // With nothing in flight the target can be fetched at once
               if (ack_s || !req_r) begin
                  pc_s = redir_tgt_s;
               end else begin
                  tgt_s   = redir_tgt_s;
                  state_s = ST_DROP;
               end
            end else if (ack_s) begin
               pc_s = pc_r + 32'd4;
               if (stall) begin
                  skid_cmd_s = imem_rdata;
                  skid_pc_s  = pc_r;
                  state_s    = ST_HOLD;
               end else begin
                  cmd_s   = imem_rdata;
                  pco_s   = pc_r;
                  valid_s = 1'b1;
               end
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_DROP: begin
            if (redirect_s) begin
               tgt_s = redir_tgt_s;
            end else begin
               tgt_s = tgt_r;
            end
            if (ack_s) begin
               pc_s    = redirect_s ? redir_tgt_s : tgt_r;
               state_s = ST_FETCH;
            end else begin
               state_s = ST_DROP;
            end
         end
         ST_HOLD: begin
            if (redirect_s) begin
               pc_s    = redir_tgt_s;
               state_s = ST_FETCH;
            end else if (!stall) begin
               cmd_s   = skid_cmd_r;
               pco_s   = skid_pc_r;
               valid_s = 1'b1;
               state_s = ST_FETCH;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_FETCH;
         end
      endcase
   end

   // State and pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_FETCH;
         pc_r       <= RESET_PC;
         tgt_r      <= 32'h0000_0000;
         skid_cmd_r <= NOP_WORD;
         skid_pc_r  <= 32'h0000_0000;
         req_r      <= 1'b0;
         cmd_r      <= NOP_WORD;
         pco_r      <= 32'h0000_0000;
         valid_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         tgt_r      <= tgt_s;
         skid_cmd_r <= skid_cmd_s;
         skid_pc_r  <= skid_pc_s;
         req_r      <= (state_s != ST_HOLD);
         cmd_r      <= cmd_s;
         pco_r      <= pco_s;
         valid_r    <= valid_s;
      end
   end

endmodule
